// File: rtl/axi_pkg.sv
// Shared types and address map for the SASD AXI read-path arbiter.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int NUM_SLV = 3;
    localparam int SLV_IM  = 0;
    localparam int SLV_DM  = 1;
    localparam int SLV_DEF = 2;

    localparam logic [15:0] IM_BASE_HI = 16'h0000;
    localparam logic [15:0] DM_BASE_HI = 16'h0001;

    // One-hot slave select from the upper address half; unmapped space goes to the default slave.
    function automatic logic [NUM_SLV-1:0] decode_slave(input logic [15:0] addr_hi);
        logic [NUM_SLV-1:0] sel;
        sel = {NUM_SLV{1'b0}};
        if (addr_hi == IM_BASE_HI) begin
            sel[SLV_IM] = 1'b1;
        end else if (addr_hi == DM_BASE_HI) begin
            sel[SLV_DM] = 1'b1;
        end else begin
            sel[SLV_DEF] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: combinational pick, registered last-grant memory.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic [1:0] pick,
    output logic       last_grant
);

    logic last_grant_r;

    // Pick the sole requester, or on contention the master not granted last.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_grant_r ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    // Remember the last completed grant; reset value favours M0 on first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (update) begin
            last_grant_r <= update_idx;
        end
    end

    assign last_grant = last_grant_r;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-path arbiter/sequencer: round-robin AR grant, slave decode, and R-burst tracking
// with burst-length checking for the SASD AXI interconnect.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int NUM_S  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid_m0,
    input  logic              arvalid_m1,
    input  logic [ADDR_W-1:0] araddr_m0,
    input  logic [ADDR_W-1:0] araddr_m1,
    input  logic [LEN_W-1:0]  arlen_m0,
    input  logic [LEN_W-1:0]  arlen_m1,
    input  logic              rready_m0,
    input  logic              rready_m1,
    input  logic [NUM_S-1:0]  arready_s,
    input  logic [NUM_S-1:0]  rvalid_s,
    input  logic [NUM_S-1:0]  rlast_s,
    output logic [1:0]        grant_m,
    output logic [NUM_S-1:0]  slave_sel,
    output logic              addr_phase,
    output logic              data_phase,
    output logic              len_err
);

    localparam int              CNT_W   = LEN_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e        state_r, state_nxt_s;
    logic [1:0]        grant_r, grant_nxt_s;
    logic [NUM_S-1:0]  sel_r, sel_nxt_s;
    logic              addr_ph_r, addr_ph_nxt_s;
    logic              data_ph_r, data_ph_nxt_s;
    logic              len_err_r, len_err_nxt_s;
    logic [LEN_W-1:0]  arlen_r, arlen_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;

    logic [1:0]        pick_s;
    logic              upd_s;
    logic              last_grant_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [LEN_W-1:0]  win_len_s;
    logic              gnt_arvalid_s, gnt_rready_s;
    logic              sel_arready_s, sel_rvalid_s, sel_rlast_s;
    logic              ar_hs_s, r_beat_s;

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        ({arvalid_m1, arvalid_m0}),
        .update     (upd_s),
        .update_idx (grant_r[1]),
        .pick       (pick_s),
        .last_grant (last_grant_s)
    );

    assign win_addr_s    = pick_s[0] ? araddr_m0 : araddr_m1;
    assign win_len_s     = pick_s[0] ? arlen_m0 : arlen_m1;
    assign gnt_arvalid_s = (grant_r[0] & arvalid_m0) | (grant_r[1] & arvalid_m1);
    assign gnt_rready_s  = (grant_r[0] & rready_m0) | (grant_r[1] & rready_m1);
    // Only the latched slave's handshake lines are observed.
    assign sel_arready_s = |(arready_s & sel_r);
    assign sel_rvalid_s  = |(rvalid_s & sel_r);
    assign sel_rlast_s   = |(rlast_s & sel_r);
    assign ar_hs_s       = (state_r == ADDR) && gnt_arvalid_s && sel_arready_s;
    assign r_beat_s      = (state_r == DATA) && sel_rvalid_s && gnt_rready_s;

    // Next-state, next-output and beat-accounting logic.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        sel_nxt_s     = sel_r;
        arlen_nxt_s   = arlen_r;
        cnt_nxt_s     = cnt_r;
        len_err_nxt_s = 1'b0;
        upd_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (arvalid_m0 || arvalid_m1) begin
                    state_nxt_s = ADDR;
                    grant_nxt_s = pick_s;
                    sel_nxt_s   = decode_slave(win_addr_s[ADDR_W-1:ADDR_W-16]);
                    arlen_nxt_s = win_len_s;
                end else begin
                    grant_nxt_s = 2'b00;
                    sel_nxt_s   = {NUM_S{1'b0}};
                end
            end
            ADDR: begin
                if (ar_hs_s) begin
                    state_nxt_s = DATA;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                if (r_beat_s) begin
                    cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                    if (sel_rlast_s) begin
                        len_err_nxt_s = (cnt_r != {1'b0, arlen_r});
                        upd_s         = 1'b1;
                        state_nxt_s   = IDLE;
                        grant_nxt_s   = 2'b00;
                        sel_nxt_s     = {NUM_S{1'b0}};
                    end else begin
                        len_err_nxt_s = (cnt_r == {1'b0, arlen_r});
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = 2'b00;
                sel_nxt_s   = {NUM_S{1'b0}};
            end
        endcase
        addr_ph_nxt_s = (state_nxt_s == ADDR);
        data_ph_nxt_s = (state_nxt_s == DATA);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, latched burst length and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r   <= 2'b00;
            sel_r     <= {NUM_S{1'b0}};
            addr_ph_r <= 1'b0;
            data_ph_r <= 1'b0;
            len_err_r <= 1'b0;
            arlen_r   <= {LEN_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            grant_r   <= grant_nxt_s;
            sel_r     <= sel_nxt_s;
            addr_ph_r <= addr_ph_nxt_s;
            data_ph_r <= data_ph_nxt_s;
            len_err_r <= len_err_nxt_s;
            arlen_r   <= arlen_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign grant_m    = grant_r;
    assign slave_sel  = sel_r;
    assign addr_phase = addr_ph_r;
    assign data_phase = data_ph_r;
    assign len_err    = len_err_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level model of grant, decode and length checks.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid_m0, arvalid_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic [3:0]  arlen_m0, arlen_m1;
    logic        rready_m0, rready_m1;
    logic [2:0]  arready_s, rvalid_s, rlast_s;
    logic [1:0]  grant_m;
    logic [2:0]  slave_sel;
    logic        addr_phase, data_phase, len_err;

    int checks = 0;
    int errors = 0;
    int last_m = 1;

    logic [7:0] obs;
    assign obs = {grant_m, slave_sel, addr_phase, data_phase, len_err};

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .arvalid_m0(arvalid_m0), .arvalid_m1(arvalid_m1),
        .araddr_m0(araddr_m0), .araddr_m1(araddr_m1),
        .arlen_m0(arlen_m0), .arlen_m1(arlen_m1),
        .rready_m0(rready_m0), .rready_m1(rready_m1),
        .arready_s(arready_s), .rvalid_s(rvalid_s), .rlast_s(rlast_s),
        .grant_m(grant_m), .slave_sel(slave_sel),
        .addr_phase(addr_phase), .data_phase(data_phase), .len_err(len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 3'b001;
        else if (a[31:16] == 16'h0001) return 3'b010;
        else return 3'b100;
    endfunction

    task automatic idle_inputs();
        arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
        rready_m0 = 1'b0; rready_m1 = 1'b0;
        arready_s = 3'b000; rvalid_s = 3'b000; rlast_s = 3'b000;
    endtask

    // One whole read transaction; abort_at >= 0 fires an async reset before that beat.
    task automatic run_txn(input logic r0, input logic r1, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] l0, input logic [3:0] l1, input int nbeats, input int ar_wait,
                           input int stall, input int gap_max, input int abort_at, input string tag);
        int w, cnt, gap;
        logic [1:0] g;
        logic [2:0] sel;
        logic [3:0] len;
        logic [7:0] exp;
        logic rdy, last, err;
        if (r0 && r1) w = (last_m == 1) ? 0 : 1;
        else if (r0) w = 0;
        else w = 1;
        g   = (w == 0) ? 2'b01 : 2'b10;
        sel = exp_sel((w == 0) ? a0 : a1);
        len = (w == 0) ? l0 : l1;
        @(negedge clk);
        arvalid_m0 = r0; arvalid_m1 = r1;
        araddr_m0 = a0; araddr_m1 = a1; arlen_m0 = l0; arlen_m1 = l1;
        arready_s = 3'b000;
        @(negedge clk);
        exp = {g, sel, 3'b100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s grant got=%b exp=%b", tag, obs, exp); end
        for (int i = 0; i < ar_wait; i++) begin
            rdy = 1'($urandom);
            arready_s = (3'($urandom) & ~sel) | (rdy ? sel : 3'b000);
            if (w == 0) arvalid_m0 = ~rdy; else arvalid_m1 = ~rdy;
            @(negedge clk);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s addr_hold got=%b exp=%b", tag, obs, exp); end
        end
        if (w == 0) arvalid_m0 = 1'b1; else arvalid_m1 = 1'b1;
        arready_s = sel | (3'($urandom) & ~sel);
        @(negedge clk);
        arvalid_m0 = 1'b0; arvalid_m1 = 1'b0; arready_s = 3'b000;
        exp = {g, sel, 3'b010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s ar_hs got=%b exp=%b", tag, obs, exp); end
        cnt = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (obs !== 8'h00) begin errors++; $display("FAIL %s async_rst got=%b exp=%b", tag, obs, 8'h00); end
                last_m = 1;
                idle_inputs();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            gap = $urandom_range(0, gap_max);
            for (int j = 0; j < gap + ((b == 0) ? stall : 0); j++) begin
                if (j < gap) begin
                    rvalid_s = 3'($urandom) & ~sel;
                    rlast_s = 3'($urandom) & ~sel;
                    rready_m0 = 1'($urandom); rready_m1 = 1'($urandom);
                end else begin
                    rvalid_s = sel | (3'($urandom) & ~sel);
                    rlast_s = 3'($urandom);
                    if (w == 0) begin rready_m0 = 1'b0; rready_m1 = 1'($urandom); end
                    else begin rready_m1 = 1'b0; rready_m0 = 1'($urandom); end
                end
                @(negedge clk);
                exp = {g, sel, 3'b010};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL %s no_beat got=%b exp=%b", tag, obs, exp); end
            end
            last = (b == nbeats - 1);
            rvalid_s = sel | (3'($urandom) & ~sel);
            rlast_s = (last ? sel : 3'b000) | (3'($urandom) & ~sel);
            if (w == 0) begin rready_m0 = 1'b1; rready_m1 = 1'($urandom); end
            else begin rready_m1 = 1'b1; rready_m0 = 1'($urandom); end
            if (last) begin arvalid_m0 = 1'($urandom); arvalid_m1 = 1'($urandom); end
            err = last ? (cnt != int'(len)) : (cnt == int'(len));
            if (cnt < 31) cnt++;
            @(negedge clk);
            rvalid_s = 3'b000; rlast_s = 3'b000; rready_m0 = 1'b0; rready_m1 = 1'b0;
            arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
            exp = last ? {7'b0000000, err} : {g, sel, 2'b01, err};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s beat%0d got=%b exp=%b", tag, b, obs, exp); end
        end
        last_m = w;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL %s idle_after got=%b exp=%b", tag, obs, 8'h00); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        last_m = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        araddr_m0 = 32'h0; araddr_m1 = 32'h0; arlen_m0 = 4'h0; arlen_m1 = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset got=%b exp=%b", obs, 8'h00); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, 8'h00); end
    endtask

    task automatic test_single_m0();
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'd0, 4'd0, 1, 1, 0, 0, -1, "single_m0");
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < 3; k++)
            run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0001_0000, 4'd1, 4'd1, 2, 1, 0, 1, -1, "contention");
    endtask

    task automatic test_burst_def();
        run_txn(1'b0, 1'b1, 32'h0, 32'h0002_0000, 4'd0, 4'd3, 4, 0, 0, 1, -1, "burst_def");
    endtask

    task automatic test_len_err();
        run_txn(1'b1, 1'b0, 32'h0001_0020, 32'h0, 4'd3, 4'd0, 2, 0, 0, 0, -1, "len_err_short");
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0008, 4'd0, 4'd1, 4, 0, 0, 0, -1, "len_err_long");
    endtask

    task automatic test_reset_mid_burst();
        run_txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'd0, 4'd0, 1, 0, 0, 0, -1, "pre_rst");
        run_txn(1'b0, 1'b1, 32'h0, 32'h0001_0004, 4'd0, 4'd3, 4, 0, 0, 0, 1, "mid_rst");
        run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h0001_0010, 4'd0, 4'd0, 1, 0, 0, 0, -1, "post_rst");
    endtask

    task automatic test_rready_stall();
        run_txn(1'b1, 1'b0, 32'h0001_0400, 32'h0, 4'd2, 4'd0, 3, 0, 5, 0, -1, "rready_stall");
    endtask

    task automatic test_saturation();
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_0000, 4'd0, 4'd15, 40, 0, 0, 0, -1, "saturate");
    endtask

    task automatic test_random();
        logic [31:0] a0, a1;
        logic [3:0] l0, l1;
        int req, nb;
        for (int k = 0; k < 25; k++) begin
            req = $urandom_range(1, 3);
            a0 = {16'($urandom_range(0, 2)), 16'($urandom)};
            a1 = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1))), 16'($urandom)};
            l0 = 4'($urandom); l1 = 4'($urandom);
            nb = $urandom_range(0, 1) ? (((req == 2) ? int'(l1) : int'(l0)) + 1) : $urandom_range(1, 18);
            if (req == 3) nb = $urandom_range(1, 18);
            run_txn(req[0], req[1], a0, a1, l0, l1, nb, $urandom_range(0, 3), $urandom_range(0, 2), 1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_contention();
        test_burst_def();
        test_len_err();
        test_reset_mid_burst();
        test_rready_stall();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
